// File: rtl/sfx_buzz_pkg.sv
// sfx_buzz_pkg: state encoding, default widths and channel names shared by the sound-effect sequencer
package sfx_buzz_pkg;
    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;
    localparam int DEF_CNT_W = 22;
    localparam int DEF_DUR_W = 24;
    localparam int CH_PADDLE = 0;
    localparam int CH_WALL   = 1;
    localparam int CH_SCORE  = 2;
    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sfx_buzz_seq_tone_div.sv
// tone_div: loadable half-period square-wave divider; tone is the bit the divider holds after the next edge
module tone_div #(
    parameter int CNT_W = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] hp,
    input  logic             run,
    output logic             tone
);
    logic [CNT_W-1:0] r_hp;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tone;
    logic             w_hit;

    assign w_hit = r_cnt == r_hp;
    // exposing the next value lets the top register it straight into sound with no extra lag
    assign tone  = load ? 1'b0 : run ? r_tone ^ w_hit : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hp   <= '0;
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else begin
            r_tone <= tone;
            if (load) begin
                r_hp  <= hp;
                r_cnt <= '0;
            end else if (run) begin
                r_cnt <= w_hit ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/sfx_buzz_seq.sv
// sfx_buzz_seq: prioritised multi-channel burst player for the buzzer; SFX_BUZZ_VOLUME_EN adds a vol PWM gate
module sfx_buzz_seq
    import sfx_buzz_pkg::*;
#(
    parameter int  NUM_CH = 3,
    parameter int  CNT_W  = DEF_CNT_W,
    parameter int  DUR_W  = DEF_DUR_W,
    localparam int CH_W   = ch_bits(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       trig,
    input  logic [NUM_CH*CNT_W-1:0] half_period,
    input  logic [NUM_CH*DUR_W-1:0] duration,
    input  logic                    mute,
`ifdef SFX_BUZZ_VOLUME_EN
    input  logic [3:0]              vol,
`endif
    output logic                    sound,
    output logic                    busy,
    output logic [CH_W-1:0]         active_ch,
    output logic [NUM_CH-1:0]       pending
);
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CH_W-1:0]   r_active_ch;
    logic [CH_W-1:0]   w_sel;
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] w_valid;
    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_pend_nxt;
    logic [DUR_W-1:0]  r_dur_cnt;
    logic [CNT_W-1:0]  w_hp;
    logic              r_sound;
    logic              w_any;
    logic              w_last;
    logic              w_load;
    logic              w_run;
    logic              w_tone;
    logic              w_gate;

    // zero-duration channels are masked out of the request vector so they never start or pend
    always_comb begin
        w_valid = '0;
        w_sel   = '0;
        for (int i = 0; i < NUM_CH; i++) w_valid[i] = |duration[i*DUR_W +: DUR_W];
        w_req = (r_pending | trig) & w_valid;
        for (int i = NUM_CH - 1; i >= 0; i--) if (w_req[i]) w_sel = CH_W'(i);
    end

    // pending bits always sit above the active channel, so w_sel < active_ch can only be a fresh trigger
    assign w_any      = |w_req;
    assign w_last     = r_dur_cnt == DUR_W'(1);
    assign w_load     = w_any && (r_state == IDLE || w_sel < r_active_ch || w_last);
    assign w_run      = r_state == PLAY && !w_load;
    assign w_hp       = half_period[w_sel*CNT_W +: CNT_W];
    assign w_pend_nxt = w_req & ~(w_load ? (NUM_CH'(1) << w_sel) : '0);

    tone_div #(.CNT_W(CNT_W)) u_tone (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .hp   (w_hp),
        .run  (w_run),
        .tone (w_tone)
    );

`ifdef SFX_BUZZ_VOLUME_EN
    logic [3:0] r_frame;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_frame <= '0;
        else     r_frame <= r_frame + 4'd1;
    end
    assign w_gate = (r_frame + 4'd1) < vol;
`else
    assign w_gate = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb w_state_nxt = w_load ? PLAY : (r_state == PLAY && w_last) ? IDLE : r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active_ch <= '0;
            r_pending   <= '0;
            r_dur_cnt   <= '0;
            r_sound     <= 1'b0;
        end else begin
            r_pending <= w_pend_nxt;
            r_sound   <= w_tone & (w_state_nxt == PLAY) & ~mute & w_gate;
            if (w_load) begin
                r_active_ch <= w_sel;
                r_dur_cnt   <= duration[w_sel*DUR_W +: DUR_W];
            end else if (r_state == PLAY) begin
                r_dur_cnt <= r_dur_cnt - DUR_W'(1);
            end
        end
    end

    always_comb begin
        busy      = r_state == PLAY;
        sound     = r_sound;
        active_ch = r_active_ch;
        pending   = r_pending;
    end
endmodule

// File: tb/tb_sfx_buzz_seq.sv
// tb_sfx_buzz_seq: directed bench for the sound-effect sequencer with hand-derived expectations
module tb_sfx_buzz_seq;
    import sfx_buzz_pkg::*;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 22;
    localparam int DUR_W  = 24;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    mute = 1'b0;
    logic [NUM_CH-1:0]       trig = '0;
    logic [NUM_CH*CNT_W-1:0] half_period = '0;
    logic [NUM_CH*DUR_W-1:0] duration = '0;
    logic                    sound;
    logic                    busy;
    logic [1:0]              active_ch;
    logic [NUM_CH-1:0]       pending;
    int                      n_tests = 0;
    int                      n_fail = 0;
`ifdef SFX_BUZZ_VOLUME_EN
    logic [3:0]              vol = 4'd15;
`endif

    sfx_buzz_seq #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DUR_W(DUR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .trig        (trig),
        .half_period (half_period),
        .duration    (duration),
        .mute        (mute),
`ifdef SFX_BUZZ_VOLUME_EN
        .vol         (vol),
`endif
        .sound       (sound),
        .busy        (busy),
        .active_ch   (active_ch),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input int ch, input int hp, input int dur);
        half_period[ch*CNT_W +: CNT_W] = CNT_W'(hp);
        duration[ch*DUR_W +: DUR_W]    = DUR_W'(dur);
    endtask

    task automatic fire(input logic [NUM_CH-1:0] t);
        trig = t;
        tick();
        trig = '0;
    endtask

    initial begin
        tick(2);
        check("rst_sound", sound, 0);
        check("rst_busy", busy, 0);
        check("rst_active", active_ch, 0);
        check("rst_pending", pending, 0);
        rst = 1'b0;
        tick(2);

        // single burst: trig at cycle 10, busy 11..30, sound high 15..18 and 23..26
        cfg(CH_PADDLE, 3, 20);
        fire(3'b001);
        check("single_active", active_ch, 0);
        for (int k = 1; k <= 21; k++) begin
            check($sformatf("single_busy_%0d", 10 + k), busy, k <= 20);
            check($sformatf("single_sound_%0d", 10 + k), sound, (k >= 5 && k <= 20 && ((k - 5) % 8) < 4));
            tick();
        end
        tick(2);

        // pre-empt ch2 with ch0, pend ch1, ch2 is not resumed
        cfg(CH_PADDLE, 1, 4);
        cfg(CH_WALL, 1, 3);
        cfg(CH_SCORE, 1, 100);
        fire(3'b100);
        check("pre_active2", active_ch, 2);
        check("pre_busy2", busy, 1);
        tick(4);
        fire(3'b001);
        check("pre_active0", active_ch, 0);
        check("pre_pend_before", pending, 3'b000);
        fire(3'b010);
        check("pre_pend_ch1", pending, 3'b010);
        check("pre_still0", active_ch, 0);
        tick(3);
        check("pre_ch1_active", active_ch, 1);
        check("pre_ch1_busy", busy, 1);
        check("pre_ch1_pend", pending, 3'b000);
        tick(3);
        check("pre_end_busy", busy, 0);
        check("pre_end_hold", active_ch, 1);
        tick(5);
        check("pre_no_resume", busy, 0);

        // simultaneous triggers with ch0 at zero duration
        cfg(CH_PADDLE, 3, 0);
        cfg(CH_WALL, 3, 5);
        cfg(CH_SCORE, 3, 3);
        fire(3'b111);
        check("sim_active1", active_ch, 1);
        check("sim_pend", pending, 3'b100);
        tick(4);
        check("sim_last_ch1", active_ch, 1);
        check("sim_last_pend", pending, 3'b100);
        tick();
        check("sim_active2", active_ch, 2);
        check("sim_busy2", busy, 1);
        check("sim_pend_clr", pending, 3'b000);
        tick(3);
        check("sim_idle", busy, 0);
        check("sim_no_ch0", pending, 3'b000);
        tick(2);

        // hp=0 toggles every cycle, then the same burst muted
        cfg(CH_SCORE, 0, 6);
        fire(3'b100);
        for (int k = 1; k <= 7; k++) begin
            check($sformatf("hp0_busy_%0d", k), busy, k <= 6);
            check($sformatf("hp0_sound_%0d", k), sound, (k <= 6 && (k % 2) == 0));
            tick();
        end
        mute = 1'b1;
        fire(3'b100);
        for (int k = 1; k <= 7; k++) begin
            check($sformatf("mute_busy_%0d", k), busy, k <= 6);
            check($sformatf("mute_sound_%0d", k), sound, 0);
            tick();
        end
        mute = 1'b0;
        tick(2);

`ifdef SFX_BUZZ_VOLUME_EN
        begin
            int cnt;
            cfg(CH_PADDLE, 40, 100);
            vol = 4'd4;
            fire(3'b001);
            tick(49);
            cnt = 0;
            for (int k = 0; k < 16; k++) begin
                cnt += int'(sound);
                tick();
            end
            check("vol4_duty", cnt, 4);
            tick(40);
            vol = 4'd0;
            fire(3'b001);
            cnt = 0;
            for (int k = 0; k < 100; k++) begin
                cnt += int'(sound);
                tick();
            end
            check("vol0_silent", cnt, 0);
            vol = 4'd15;
            tick(3);
        end
`endif

        // reset mid-burst clears outputs before the next clock edge
        cfg(CH_WALL, 2, 50);
        fire(3'b010);
        fire(3'b100);
        check("mid_pend", pending, 3'b100);
        tick(2);
        check("mid_sound_hi", sound, 1);
        check("mid_active", active_ch, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_sound", sound, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pend", pending, 0);
        check("mid_rst_active", active_ch, 0);
        tick();
        rst = 1'b0;
        tick(3);
        check("mid_after_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sfx_buzz_seq.md
Name: sfx_buzz_seq

Overview:
- Parametrised multi-channel sound-effect generator for the pong game.
- Each of NUM_CH channels (e.g. paddle hit, wall bounce, score) has a programmable tone half-period and burst duration.
- A one-cycle trigger on a channel plays a square-wave burst on the single buzzer output.
- Fixed priority arbitration, pre-emption and per-channel pending latches; replaces the free-running single-tone buzzer.

Parameters:
- NUM_CH, 3: number of effect channels. Channel 0 has the highest priority.
- CNT_W, 22: width of the tone half-period counter.
- DUR_W, 24: width of the burst-duration counter, in clk cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- trig  in  NUM_CH  one-cycle effect requests, one bit per channel
- half_period  in  NUM_CH*CNT_W  per-channel half-period; channel i occupies bits [i*CNT_W +: CNT_W]
- duration  in  NUM_CH*DUR_W  per-channel burst length in cycles; channel i occupies bits [i*DUR_W +: DUR_W]
- mute  in  1  forces sound low; counters keep running
- sound  out  1  buzzer drive, registered
- busy  out  1  high while in PLAY
- active_ch  out  $clog2(NUM_CH)  channel currently playing; holds its last value when idle
- pending  out  NUM_CH  latched requests not yet served

Behaviour:
- Reset (async, rst=1): state=IDLE; sound=0, busy=0, active_ch=0, pending=0; all counters cleared.
- The effective request vector each cycle is req = pending | trig.
- Channels with duration==0 are never started.
  - Their trig bit is dropped and never enters pending.
- IDLE:
  - If req is non-zero, select the lowest-index set bit c.
  - Next cycle: state=PLAY, active_ch=c, busy=1, tone_cnt=0, dur_cnt=duration[c], sound=0, and pending bit c cleared.
  - hp and duration are sampled at the load cycle only; later changes are ignored until the next load.
- PLAY, every cycle:
  - If tone_cnt==hp: invert the internal tone bit and clear tone_cnt; otherwise increment tone_cnt.
  - hp==0 gives a toggle every cycle.
  - dur_cnt decrements by 1.
  - When dur_cnt reaches 1, the next state is IDLE (or a reload if req is non-zero). The burst therefore lasts exactly duration[c] cycles.
  - On leaving PLAY, sound returns to 0.
  - Latency: trig asserted at cycle n gives busy=1 at n+1; first sound rise at n+1+hp+1.
- Pre-emption:
  - A trig on channel k<active_ch while in PLAY restarts immediately as a fresh load for k.
  - The interrupted channel is not resumed and not re-pended.
- Triggers on k>=active_ch during PLAY set pending[k].
  - A retrigger of active_ch itself is pended, not restarted.
  - Repeated triggers on a channel collapse into one pending bit.
- Simultaneous trig on several channels: the lowest index wins; the others go to pending.
- mute=1: sound=0; state and counters are unaffected.
- sound is registered: it equals the internal tone bit AND busy AND NOT mute, delayed 0 cycles (it is the register itself).

Optional Feature:
- Macro: SFX_BUZZ_VOLUME_EN
- Enabled:
  - Adds input vol[3:0].
  - A free-running 4-bit PWM frame counter runs from reset.
  - sound = tone & (frame < vol).
  - vol=0 means silent; vol=15 gives 15/16 duty gating.
- Disabled: no vol port and no frame counter; behaviour as above, equivalent to full volume.

Decomposition:
- Package sfx_buzz_pkg holds:
  - the state enum (IDLE, PLAY);
  - default widths (CNT_W=22, DUR_W=24);
  - localparam named channel indices CH_PADDLE=0, CH_WALL=1, CH_SCORE=2.
- Sub-module tone_div: loadable half-period square-wave divider.
  - Ports: clk, rst, load, hp, run, tone.
  - Instantiated once.
  - The top level owns arbitration, pending and duration.

Test Plan:
- Reset mid-burst: ch1 playing, assert rst -> sound=0, busy=0 and pending=0 asynchronously, before the next clk edge.
- Single burst: hp[0]=3, dur[0]=20, trig[0] pulse at cycle 10 -> busy high cycles 11..30; sound period 8 cycles, first rise at cycle 15; idle and sound=0 at 31.
- Pre-empt and pend: ch2 playing (dur=100), trig[0] at +5 and trig[1] at +6 -> ch0 loads at +6; pending=3'b010; after ch0 ends, ch1 plays; ch2 never resumes.
- Simultaneous and zero-duration: trig=3'b111 with dur[0]=0 -> ch1 plays, pending=3'b100, ch0 dropped; ch2 plays on the cycle after ch1 ends.
- hp=0 and mute: hp[2]=0, dur=6 -> sound toggles every cycle for 6 cycles; repeat with mute=1 -> sound stays 0 while busy still spans 6 cycles.
- SFX_BUZZ_VOLUME_EN defined, vol=4, hp large -> during tone-high periods sound is high exactly 4 of every 16 cycles; vol=0 -> sound constantly 0.
